fpga_link_master: RTL and testbench

Parametrised master end of the FPGA-to-FPGA serial link. It generates the bit clock, drives the slave sync strobe, shifts out `NWORDS` words of `WORD_W` bits and samples the same number of bits back. It presents the received frame atomically with a one-cycle `done` pulse. It sits between the dSPACE-facing control logic, which issues `start` and supplies and consumes data, and the inter-board pins.

---
 rtl/fpga_link_pkg.sv | 26 ++
 rtl/fpga_link_bit_timer.sv | 66 ++++++
 rtl/fpga_link_master.sv | 210 +++++++++++++++++++++
 tb/tb_fpga_link_master.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/fpga_link_pkg.sv
// ---------------------------------------------------------------------------
// fpga_link_pkg
// Shared definitions for the FPGA-to-FPGA serial link master:
//   - link_state_e : FSM state encoding (IDLE, SYNC, XFER, LATCH)
//   - MAX_WORDS / MAX_WORD_W : upper bounds of the frame geometry
//   - frame_bits() : number of bits moved per frame (data + optional parity)
// ---------------------------------------------------------------------------
package fpga_link_pkg;

  localparam int MAX_WORDS  = 16;
  localparam int MAX_WORD_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SYNC  = 2'd1,
    ST_XFER  = 2'd2,
    ST_LATCH = 2'd3
  } link_state_e;

  // Bits shifted per frame; the parity bit, when enabled, trails the data.
  function automatic int frame_bits(input int nwords, input int word_w,
                                    input bit parity_en);
    return nwords * word_w + (parity_en ? 1 : 0);
  endfunction

endpackage

// File: rtl/fpga_link_bit_timer.sv
// ---------------------------------------------------------------------------
// fpga_link_bit_timer
// Bit-period counter for the link master. Counts 0..rate while run is high
// and sits at 0 otherwise, and decodes the per-bit strobes from the count.
//
// Parameters:
//   SAMPLE_OFFSET : extra cycles after mid-bit before the sample strobe
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   run_i           : count enable (frame in SYNC or XFER)
//   rate_i [7:0]    : latched bit period minus one
//   bit_end_o       : count equals rate (last cycle of the bit)
//   sample_o        : count equals the (clamped) sample point
//   sync_window_o   : count is within the first half of the bit
// ---------------------------------------------------------------------------
module fpga_link_bit_timer #(
  parameter int SAMPLE_OFFSET = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run_i,
  input  logic [7:0] rate_i,
  output logic       bit_end_o,
  output logic       sample_o,
  output logic       sync_window_o
);

  // Offsets beyond a full maximum bit period always clamp, so cap the
  // constant to keep the sum arithmetic narrow.
  localparam int         OFS_C = (SAMPLE_OFFSET > 255) ? 255 :
                                 ((SAMPLE_OFFSET < 0) ? 0 : SAMPLE_OFFSET);
  localparam logic [8:0] OFS_9 = 9'(OFS_C);

  logic [7:0] cnt_q, cnt_d;
  logic [8:0] sample_sum;
  logic [7:0] sample_pt;

  always_comb begin
    cnt_d = cnt_q;
    if (!run_i) begin
      cnt_d = '0;
    end else if (cnt_q == rate_i) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Mid-bit plus board delay, clamped to the last cycle of the bit so a
  // large offset at a slow-to-fast rate never skips the sample entirely.
  assign sample_sum = {2'b00, rate_i[7:1]} + OFS_9;
  assign sample_pt  = (sample_sum > {1'b0, rate_i}) ? rate_i : sample_sum[7:0];

  assign bit_end_o     = (cnt_q == rate_i);
  assign sample_o      = (cnt_q == sample_pt);
  assign sync_window_o = (cnt_q <= {1'b0, rate_i[7:1]});

endmodule

// File: rtl/fpga_link_master.sv
// ---------------------------------------------------------------------------
// fpga_link_master
// Master end of the inter-board serial link. On start it sends a one-bit-
// period start/sync symbol, then shifts NWORDS*WORD_W bits out MSB first
// while sampling the same number of bits back, and finally presents the
// received frame on rx_data together with a one-cycle done pulse.
//
// Optional feature (compile-time macro FPGA_LINK_PARITY_EN): an even-parity
// bit is appended to the transmitted frame, one extra bit is received and
// checked, and the result is reported on parity_err.
//
// Parameters:
//   NWORDS        : words per frame (1..16)
//   WORD_W        : bits per word (1..16)
//   SAMPLE_OFFSET : extra clk cycles after mid-bit before sampling serial_in
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   start          : one-cycle frame request, honoured only when idle
//   bit_rate [7:0] : bit period minus one (3..255), captured at start
//   tx_data        : frame to send, word 0 in the MSBs, captured at start
//   rx_data        : last received frame, same packing as tx_data
//   done           : one-cycle pulse, rx_data valid in the same cycle
//   busy           : frame in progress (cycle after start through done)
//   serial_out     : line to the slave
//   serial_in      : line from the slave
//   sync_slave     : sync strobe during the first half of the start bit
//   reset_slave    : combinational copy of rst
//   parity_err     : parity mismatch of the last frame (parity build only)
// ---------------------------------------------------------------------------
module fpga_link_master
  import fpga_link_pkg::*;
#(
  parameter int NWORDS        = 3,
  parameter int WORD_W        = 4,
  parameter int SAMPLE_OFFSET = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [7:0]               bit_rate,
  input  logic [NWORDS*WORD_W-1:0] tx_data,
  output logic [NWORDS*WORD_W-1:0] rx_data,
  output logic                     done,
  output logic                     busy,
  output logic                     serial_out,
  input  logic                     serial_in,
  output logic                     sync_slave,
  output logic                     reset_slave
`ifdef FPGA_LINK_PARITY_EN
  ,
  output logic                     parity_err
`endif
);

`ifdef FPGA_LINK_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  localparam int DW    = NWORDS * WORD_W;
  localparam int FB    = frame_bits(NWORDS, WORD_W, PARITY_EN);
  localparam int IDX_W = (FB > 1) ? $clog2(FB) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FB - 1);

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_SYNC  = ST_SYNC;
  localparam logic [1:0] S_XFER  = ST_XFER;
  localparam logic [1:0] S_LATCH = ST_LATCH;

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       rate_q, rate_d;
  logic [FB-1:0]    tx_q, tx_d;
  logic [FB-1:0]    rx_q, rx_d;
  logic [FB-1:0]    frame_load;
  logic [DW-1:0]    rx_frame;

  logic             rx_data_q_valid_unused;
  logic [DW-1:0]    rx_data_q;
  logic             done_q, busy_q, serial_out_q, sync_slave_q;

  logic             timer_run;
  logic             bit_end, sample, sync_window;

`ifdef FPGA_LINK_PARITY_EN
  logic             parity_err_q;
  assign frame_load = {tx_data, ^tx_data};
  assign rx_frame   = rx_q[FB-1:1];
`else
  assign frame_load = tx_data;
  assign rx_frame   = rx_q;
`endif

  assign rx_data_q_valid_unused = 1'b0;

  assign timer_run = (state_q == S_SYNC) || (state_q == S_XFER);

  fpga_link_bit_timer #(
    .SAMPLE_OFFSET (SAMPLE_OFFSET)
  ) u_bit_timer (
    .clk           (clk),
    .rst           (rst),
    .run_i         (timer_run),
    .rate_i        (rate_q),
    .bit_end_o     (bit_end),
    .sample_o      (sample),
    .sync_window_o (sync_window)
  );

  // Next-state and shift-register update
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rate_d  = rate_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SYNC;
          rate_d  = bit_rate;
          tx_d    = frame_load;
        end
      end
      S_SYNC: begin
        if (bit_end) begin
          state_d = S_XFER;
          idx_d   = '0;
        end
      end
      S_XFER: begin
        // Shift-in form works for a single-bit frame as well.
        if (sample) begin
          rx_d = (rx_q << 1) | FB'(serial_in);
        end
        if (bit_end) begin
          tx_d = tx_q << 1;
          if (idx_q == IDX_LAST) begin
            state_d = S_LATCH;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      S_LATCH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      rate_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      serial_out_q <= 1'b0;
      sync_slave_q <= 1'b0;
      rx_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      rate_q       <= rate_d;
      // Outputs decode the current state, so they trail it by one cycle.
      busy_q       <= (state_q != S_IDLE);
      done_q       <= (state_q == S_LATCH);
      sync_slave_q <= (state_q == S_SYNC) && sync_window;
      case (state_q)
        S_SYNC:  serial_out_q <= 1'b1;
        S_XFER:  serial_out_q <= tx_q[FB-1];
        default: serial_out_q <= 1'b0;
      endcase
      if (state_q == S_LATCH) begin
        rx_data_q <= rx_frame;
      end
    end
  end

`ifdef FPGA_LINK_PARITY_EN
  // Even parity over data plus received parity bit must reduce to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      parity_err_q <= 1'b0;
    end else if (state_q == S_LATCH) begin
      parity_err_q <= ^rx_q;
    end
  end
  assign parity_err = parity_err_q;
`endif

  // Shift registers carry data only and need no reset
  always_ff @(posedge clk) begin
    tx_q <= tx_d;
    rx_q <= rx_d;
  end

  assign rx_data     = rx_data_q;
  assign done        = done_q;
  assign busy        = busy_q;
  assign serial_out  = serial_out_q;
  assign sync_slave  = sync_slave_q;
  assign reset_slave = rst | rx_data_q_valid_unused;

endmodule

// File: tb/tb_fpga_link_master.sv
// ---------------------------------------------------------------------------
// tb_fpga_link_master
// Self-checking bench for fpga_link_master (NWORDS=3, WORD_W=4,
// SAMPLE_OFFSET=3). serial_in is a loopback of serial_out with optional
// inversion at chosen cycles. Cycle k of a frame is the value seen 1 time
// unit after the k-th rising edge following the edge that sampled start.
// ---------------------------------------------------------------------------
module tb_fpga_link_master;

  localparam int DW  = 12;
  localparam int OFS = 3;
`ifdef FPGA_LINK_PARITY_EN
  localparam int FB = DW + 1;
`else
  localparam int FB = DW;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [7:0]    bit_rate = 8'd7;
  logic [DW-1:0] tx_data = '0;
  logic [DW-1:0] rx_data;
  logic          done, busy, serial_out, serial_in, sync_slave, reset_slave;
  logic          flip = 1'b0;
`ifdef FPGA_LINK_PARITY_EN
  logic          par_err;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  assign serial_in = serial_out ^ flip;

  always #5 clk = ~clk;

  fpga_link_master #(
    .NWORDS        (3),
    .WORD_W        (4),
    .SAMPLE_OFFSET (OFS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .bit_rate    (bit_rate),
    .tx_data     (tx_data),
    .rx_data     (rx_data),
    .done        (done),
    .busy        (busy),
    .serial_out  (serial_out),
    .serial_in   (serial_in),
    .sync_slave  (sync_slave),
    .reset_slave (reset_slave)
`ifdef FPGA_LINK_PARITY_EN
    ,
    .parity_err  (par_err)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Frame bit j on the line: data MSB first, then the even-parity bit.
  function automatic bit line_bit(input logic [DW-1:0] tx, input int j);
    if (j < DW) return tx[DW-1-j];
    return ^tx;
  endfunction

  // Whether the line is inverted during cycle c of the frame.
  function automatic bit flip_at(input int c, input int fj, input bit narrow,
                                 input int p, input int s);
    if (fj < 0) return 1'b0;
    if (narrow) return (c == (fj + 1) * p + s);
    return (c >= (fj + 1) * p + 1) && (c <= (fj + 2) * p);
  endfunction

  task automatic run_frame(input logic [DW-1:0] tx, input logic [7:0] br,
                           input int flip_j, input bit narrow, input int extra_k);
    int p, d, s, j;
    logic [DW-1:0] exp_rx;
    bit exp_pe, exp_so;
    p = int'(br) + 1;
    d = 1 + (FB + 1) * p;
    s = int'(br >> 1) + OFS;
    if (s > int'(br)) s = int'(br);
    exp_rx = tx;
    exp_pe = 1'b0;
    if (flip_j >= 0) begin
      if (flip_j < DW) exp_rx[DW-1-flip_j] = ~exp_rx[DW-1-flip_j];
      exp_pe = 1'b1;
    end
    start = 1'b1; tx_data = tx; bit_rate = br;
    @(posedge clk); #1;
    // Inputs after start must not disturb the captured frame.
    tx_data  = DW'($urandom);
    bit_rate = 8'($urandom_range(3, 255));
    for (int k = 1; k <= d + 3; k++) begin
      flip  = flip_at(k - 1, flip_j, narrow, p, s);
      start = (k - 1 == extra_k);
      @(posedge clk); #1;
      if (k <= p) exp_so = 1'b1;
      else if (k <= (FB + 1) * p) begin
        j = (k - 1) / p - 1;
        exp_so = line_bit(tx, j);
      end else exp_so = 1'b0;
      chk("busy", 32'(busy), 32'(k <= d));
      chk("done", 32'(done), 32'(k == d));
      chk("serial_out", 32'(serial_out), 32'(exp_so));
      chk("sync_slave", 32'(sync_slave), 32'((k >= 1) && (k <= 1 + int'(br >> 1))));
      if (k >= d) begin
        chk("rx_data", 32'(rx_data), 32'(exp_rx));
`ifdef FPGA_LINK_PARITY_EN
        chk("parity_err", 32'(par_err), 32'(exp_pe));
`endif
      end
    end
    start = 1'b0;
    flip  = 1'b0;
  endtask

  task automatic reset_mid(input logic [DW-1:0] tx, input logic [7:0] br, input int rk);
    start = 1'b1; tx_data = tx; bit_rate = br; flip = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= rk; k++) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1 chk("reset_slave_hi", 32'(reset_slave), 32'd1);
    @(posedge clk); #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_serial_out", 32'(serial_out), 32'd0);
    chk("rst_sync", 32'(sync_slave), 32'd0);
    chk("rst_rx_data", 32'(rx_data), 32'd0);
`ifdef FPGA_LINK_PARITY_EN
    chk("rst_parity_err", 32'(par_err), 32'd0);
`endif
    rst = 1'b0;
    #1 chk("reset_slave_lo", 32'(reset_slave), 32'd0);
    for (int k = 0; k < 120; k++) begin
      @(posedge clk); #1;
      chk("post_rst_done", 32'(done), 32'd0);
      chk("post_rst_busy", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    int fj;
    // Reset state, including start asserted together with rst.
    start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b0;
    chk("reset_rx_data", 32'(rx_data), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_serial_out", 32'(serial_out), 32'd0);
    chk("reset_sync", 32'(sync_slave), 32'd0);
    chk("reset_slave_on", 32'(reset_slave), 32'd1);
`ifdef FPGA_LINK_PARITY_EN
    chk("reset_parity_err", 32'(par_err), 32'd0);
`endif
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_busy", 32'(busy), 32'd0);
    chk("reset_slave_off", 32'(reset_slave), 32'd0);

    // Loopback at rate 7, sync strobe and serial_out pattern.
    run_frame(12'h9CD, 8'd7, -1, 1'b0, -1);
    // Start during the frame is ignored.
    run_frame(12'h9CD, 8'd7, -1, 1'b0, 50);
    // Reset mid-frame, then a clean frame.
    reset_mid(12'h9CD, 8'd7, 60);
    run_frame(12'h123, 8'd7, -1, 1'b0, -1);
`ifdef FPGA_LINK_PARITY_EN
    // Corrupt the parity bit over its whole bit period.
    run_frame(12'h9CD, 8'd7, FB - 1, 1'b0, -1);
`endif
    // Minimum rate with the sample point clamped to the last cycle.
    run_frame(12'hFFF, 8'd3, -1, 1'b0, -1);
    run_frame(12'h000, 8'd3, -1, 1'b0, -1);

    // Randomised frames, some with a single corrupted sample.
    for (int n = 0; n < 12; n++) begin
      fj = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, FB - 1));
      run_frame(DW'($urandom), 8'($urandom_range(3, 20)), fj, 1'b1,
                int'($urandom_range(0, 40)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
